j1_irq_ctrl: RTL and testbench
==============================

Name: j1_irq_ctrl

Overview:
- Interrupt controller that produces the 8-bit one-hot-priority `int_rqst` vector consumed by the j1 core. Bit 7 has the highest priority; the core does the priority encoding.
- Synchronises eight asynchronous event lines, detects edges of programmable polarity and latches them as pending. Gates pending events with an enable mask.
- Sits on the j1 IO bus, driven by `io_rd`, `io_wr`, `mem_addr` and `dout`. Software reads status and clears events there.
- The core has no acknowledge line, so the ISR acknowledges by an explicit write-1-to-clear.

Parameters:
- ADDR_PEND, 16'h0400, IO address of the pending register. Read: pending. Write: 1 bits clear the matching pending bits.
- ADDR_MASK, 16'h0401, IO address of the enable mask register. Read/write.
- ADDR_POL, 16'h0402, IO address of the edge polarity register. Read/write. 0 = rising edge, 1 = falling edge.
- ADDR_SET, 16'h0403, IO address of the software set register. Write: 1 bits set the matching pending bits. Reads return 0.
- NSRC, 8, number of sources. Fixed at 8; any other value is unsupported.

Ports:
- clk  in  1  system clock
- resetq  in  1  reset, asynchronous, active-low
- irq_in  in  8  asynchronous event lines from peripherals
- io_rd  in  1  IO read strobe from the core
- io_wr  in  1  IO write strobe from the core
- io_addr  in  16  IO address, connected to core `mem_addr`
- io_wdata  in  16  IO write data, connected to core `dout`
- io_rdata  out  16  read data. Combinational. Zero when not selected, so it can be OR-merged into `io_din`.
- io_rsel  out  1  high when `io_rd` targets one of this block's addresses
- int_rqst  out  8  registered request vector to the core, equal to `pending & mask`

Behaviour:
- Reset, asynchronous, all to 0: sync stages s1/s2/s3, pending, mask, pol, int_rqst. With pol=0 and s flops at 0, an `irq_in` line already high when reset is released is detected as a rising edge. This is intended behaviour; software clears pending after enabling.
- Synchroniser per bit: s1 <= irq_in, s2 <= s1, s3 <= s2.
- Edge detect per bit: x = s2 ^ pol, xp = s3 ^ pol, hw_evt = x & ~xp.
- Writing POL changes both x and xp in the same cycle, so a POL write alone generates no event.
- Latency: an `irq_in` transition that meets setup before edge 0 gives pending[i]=1 after edge 2 and int_rqst[i]=1 after edge 3 (if mask[i]=1).
- Minimum detectable pulse: 2 clk periods high, then 2 low, for repeated detection. Shorter pulses may be lost.
- Pending update each clk: pending <= (pending & ~clr) | hw_evt | swset.
  - clr = io_wdata[7:0] when io_wr & io_addr==ADDR_PEND, else 0.
  - swset = io_wdata[7:0] when io_wr & io_addr==ADDR_SET, else 0.
  - A set (hardware edge or software) wins over a clear on the same bit in the same cycle, so no event is lost.
  - A new edge on an already-pending bit is absorbed; there is no counting.
- mask <= io_wdata[7:0] on a write to ADDR_MASK. pol <= io_wdata[7:0] on a write to ADDR_POL.
- io_wdata[15:8] is ignored on all writes.
- int_rqst <= pending & mask, registered one cycle after pending/mask update.
  - A clear written at edge n drops int_rqst at edge n+1.
  - The ISR must clear at least 2 instructions before its return/eint, or the same source re-enters.
- Read:
  - io_rsel = io_rd & (io_addr is one of the 4 addresses).
  - io_rdata = {8'h00, reg} for PEND/MASK/POL; 16'h0000 for SET, unmatched addresses, or io_rd low.
  - Reads have no side effects.
  - io_rdata is purely combinational from registers and address, because the core samples it in the same cycle.
- Writes to unmatched addresses are ignored. io_rd and io_wr never coincide (core guarantees); if they do, both take effect.
- Reset asserted mid-operation: all state clears immediately and int_rqst drops asynchronously.

Test Plan:
- Rising-edge latency: pol=0, mask=8'h80, raise irq_in[7] before edge 0 → pending=8'h80 after edge 2, int_rqst=8'h80 after edge 3, PEND read returns 16'h0080, io_rsel=1.
- Falling edge plus masking: pol=8'h01, mask=0, drop irq_in[0] from 1 to 0 → pending=8'h01, int_rqst stays 0; write mask=8'h01 → int_rqst=8'h01 one cycle later.
- Write-1-to-clear collision: pending=8'h06, write 8'h02 to ADDR_PEND in the same cycle a rising edge reaches hw_evt on bit 1 → pending stays 8'h06. Repeat without the edge → pending=8'h04.
- Software set and multi-source: write 8'hA5 to ADDR_SET, mask=8'hFF → int_rqst=8'hA5 one cycle later. Read ADDR_SET → 16'h0000. Write 8'hA5 to ADDR_PEND → int_rqst=0 two edges after the write.
- POL write with static input: irq_in=8'hFF, pending cleared, write pol=8'hFF then pol=8'h00 → pending stays 0. Unmatched address read (16'h0404) → io_rdata=0, io_rsel=0.
- Asynchronous reset mid-request: int_rqst=8'h10, assert resetq low between edges → int_rqst, pending and mask are 0 before the next edge. After release with irq_in=0, no event appears.

Source files
------------

// File: rtl/j1_irq_ctrl_if.sv
// IO bus between the j1 core and the interrupt controller.
// The core (master) drives strobes, address and write data; the slave returns
// combinational read data and a select flag for OR-merging into io_din.
interface j1_irq_ctrl_if;
   logic        io_rd;
   logic        io_wr;
   logic [15:0] io_addr;
   logic [15:0] io_wdata;
   logic [15:0] io_rdata;
   logic        io_rsel;

   modport master (output io_rd, io_wr, io_addr, io_wdata,
                   input  io_rdata, io_rsel);
   modport slave  (input  io_rd, io_wr, io_addr, io_wdata,
                   output io_rdata, io_rsel);
endinterface

// File: rtl/j1_irq_ctrl.sv
// j1 interrupt controller: per-source synchroniser, polarity-selectable edge
// detect and sticky pending bit, plus the shared mask/polarity registers,
// registered request vector and IO read mux.

// One interrupt source: 3-flop synchroniser, edge detect, pending latch.
module j1_irq_src (
   input  logic clk,
   input  logic resetq,
   input  logic irq_in,
   input  logic pol,
   input  logic clr,
   input  logic swset,
   output logic pend
);
   logic s1, s2, s3;
   logic hw_evt;

   // Synchronise the async line; s3 holds the previous synchronised level.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= irq_in;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // Both taps are flipped by pol together, so a pol change alone is no edge.
   assign hw_evt = (s2 ^ pol) & ~(s3 ^ pol);

   // Sticky pending bit; any set beats a same-cycle clear so no event is lost.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) pend <= 1'b0;
      else         pend <= (pend & ~clr) | hw_evt | swset;
   end
endmodule

module j1_irq_ctrl #(
   parameter logic [15:0] ADDR_PEND = 16'h0400,
   parameter logic [15:0] ADDR_MASK = 16'h0401,
   parameter logic [15:0] ADDR_POL  = 16'h0402,
   parameter logic [15:0] ADDR_SET  = 16'h0403,
   parameter int          NSRC      = 8
) (
   input  logic               clk,
   input  logic               resetq,
   input  logic [NSRC-1:0]    irq_in,
   j1_irq_ctrl_if.slave       io,
   output logic [NSRC-1:0]    int_rqst
);
   logic [NSRC-1:0] pending, mask, pol, clr, swset;
   logic            sel_pend, sel_mask, sel_pol, sel_set;
   logic [15:0]     rdata;
   logic            unused_wdata_hi;

   assign sel_pend = (io.io_addr == ADDR_PEND);
   assign sel_mask = (io.io_addr == ADDR_MASK);
   assign sel_pol  = (io.io_addr == ADDR_POL);
   assign sel_set  = (io.io_addr == ADDR_SET);

   assign clr   = (io.io_wr && sel_pend) ? io.io_wdata[NSRC-1:0] : '0;
   assign swset = (io.io_wr && sel_set)  ? io.io_wdata[NSRC-1:0] : '0;

   // Upper write-data byte carries nothing for this block.
   assign unused_wdata_hi = &{1'b0, io.io_wdata[15:NSRC]};

   genvar i;
   generate
      for (i = 0; i < NSRC; i++) begin : g_src
         j1_irq_src u_src (
            .clk    (clk),
            .resetq (resetq),
            .irq_in (irq_in[i]),
            .pol    (pol[i]),
            .clr    (clr[i]),
            .swset  (swset[i]),
            .pend   (pending[i])
         );
      end
   endgenerate

   // Software-owned mask and polarity registers.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) begin
         mask <= '0;
         pol  <= '0;
      end else begin
         if (io.io_wr && sel_mask) mask <= io.io_wdata[NSRC-1:0];
         if (io.io_wr && sel_pol)  pol  <= io.io_wdata[NSRC-1:0];
      end
   end

   // Registered request vector; the core does the priority encoding.
   always_ff @(posedge clk or negedge resetq) begin
      if (!resetq) int_rqst <= '0;
      else         int_rqst <= pending & mask;
   end

   // Read mux is combinational: the core samples io_din in the same cycle.
   always_comb begin
      rdata = '0;
      if (io.io_rd) begin
         if (sel_pend)      rdata = {{(16-NSRC){1'b0}}, pending};
         else if (sel_mask) rdata = {{(16-NSRC){1'b0}}, mask};
         else if (sel_pol)  rdata = {{(16-NSRC){1'b0}}, pol};
      end
   end

   assign io.io_rdata = rdata;
   assign io.io_rsel  = io.io_rd & (sel_pend | sel_mask | sel_pol | sel_set);
endmodule

// File: tb/tb_j1_irq_ctrl.sv
// Scoreboard bench for j1_irq_ctrl: stimulus pushes the expected outputs for
// each cycle, a negedge monitor pops and compares them against the DUT.
module tb_j1_irq_ctrl;
   localparam logic [15:0] A_PEND = 16'h0400;
   localparam logic [15:0] A_MASK = 16'h0401;
   localparam logic [15:0] A_POL  = 16'h0402;
   localparam logic [15:0] A_SET  = 16'h0403;

   logic       clk = 1'b0;
   logic       resetq = 1'b0;
   logic [7:0] irq_in = 8'h00;
   logic [7:0] int_rqst;
   logic [7:0] cur_irq = 8'h00;

   j1_irq_ctrl_if io ();

   j1_irq_ctrl dut (
      .clk      (clk),
      .resetq   (resetq),
      .irq_in   (irq_in),
      .io       (io),
      .int_rqst (int_rqst)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]  rq;
      logic        rsel;
      logic [15:0] rdata;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference state: register contents plus the log of irq_in levels seen
   // at each clock edge since reset.
   logic [7:0] m_pend, m_mask, m_pol, m_rq;
   logic [7:0] m_log[$];

   // Level sampled k edges ago (lines read as low before reset release).
   function automatic logic [7:0] past(int k);
      if (m_log.size() >= k) return m_log[m_log.size() - k];
      return 8'h00;
   endfunction

   function automatic void model_reset();
      m_pend = 8'h00; m_mask = 8'h00; m_pol = 8'h00; m_rq = 8'h00;
      m_log.delete();
   endfunction

   // Apply one clock edge: an event is a line that, seen through the current
   // polarity, was active two samples ago and inactive three samples ago.
   function automatic void model_edge();
      logic [7:0] evt, clr, set, rq_new;
      evt    = (past(2) ^ m_pol) & ~(past(3) ^ m_pol);
      clr    = (io.io_wr && io.io_addr == A_PEND) ? io.io_wdata[7:0] : 8'h00;
      set    = (io.io_wr && io.io_addr == A_SET)  ? io.io_wdata[7:0] : 8'h00;
      rq_new = m_pend & m_mask;
      m_pend = (m_pend & ~clr) | evt | set;
      if (io.io_wr && io.io_addr == A_MASK) m_mask = io.io_wdata[7:0];
      if (io.io_wr && io.io_addr == A_POL)  m_pol  = io.io_wdata[7:0];
      m_rq = rq_new;
      m_log.push_back(irq_in);
      if (m_log.size() > 8) void'(m_log.pop_front());
   endfunction

   function automatic void push_exp();
      exp_t e;
      e.rq    = m_rq;
      e.rsel  = io.io_rd && (io.io_addr >= A_PEND) && (io.io_addr <= A_SET);
      e.rdata = 16'h0000;
      if (io.io_rd) begin
         case (io.io_addr)
            A_PEND:  e.rdata = {8'h00, m_pend};
            A_MASK:  e.rdata = {8'h00, m_mask};
            A_POL:   e.rdata = {8'h00, m_pol};
            default: e.rdata = 16'h0000;
         endcase
      end
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
      end
   endtask

   // Monitor: every cycle the DUT presents int_rqst and the read response.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("int_rqst", {8'h00, int_rqst}, {8'h00, e.rq});
         check("io_rsel", {15'h0, io.io_rsel}, {15'h0, e.rsel});
         check("io_rdata", io.io_rdata, e.rdata);
      end
   end

   // One bus cycle, entered and left 1 time unit after a rising edge.
   task automatic step(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata);
      irq_in      = cur_irq;
      io.io_rd    = rd;
      io.io_wr    = wr;
      io.io_addr  = addr;
      io.io_wdata = wdata;
      push_exp();
      @(posedge clk);
      if (resetq) model_edge();
      #1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000);
   endtask

   task automatic wr(input logic [15:0] addr, input logic [15:0] data);
      step(1'b0, 1'b1, addr, data);
   endtask

   task automatic rd(input logic [15:0] addr);
      step(1'b1, 1'b0, addr, 16'h0000);
   endtask

   // Assert reset between edges, hold it across one edge, then release.
   task automatic do_reset();
      resetq      = 1'b0;
      irq_in      = cur_irq;
      io.io_rd    = 1'b0;
      io.io_wr    = 1'b0;
      io.io_addr  = 16'h0000;
      io.io_wdata = 16'h0000;
      model_reset();
      push_exp();
      @(posedge clk);
      #1;
      resetq = 1'b1;
   endtask

   initial begin
      io.io_rd = 1'b0; io.io_wr = 1'b0; io.io_addr = 16'h0; io.io_wdata = 16'h0;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();
      rd(A_PEND); rd(A_MASK); rd(A_POL);

      // Rising edge on bit 7, latency and PEND read.
      wr(A_POL, 16'h0000); wr(A_MASK, 16'h0080);
      cur_irq[7] = 1'b1;
      idle(4); rd(A_PEND);
      wr(A_PEND, 16'hFFFF); idle(2);

      // Falling edge on bit 0 while masked, then unmask.
      cur_irq[0] = 1'b1; idle(4);
      wr(A_POL, 16'h0001); wr(A_MASK, 16'h0000); wr(A_PEND, 16'h00FF);
      cur_irq[0] = 1'b0; idle(4); rd(A_PEND);
      wr(A_MASK, 16'h0001); idle(2);

      // Clear colliding with a hardware edge on bit 1, then without it.
      wr(A_PEND, 16'h00FF); wr(A_SET, 16'h0006); idle(2);
      cur_irq[1] = 1'b1; idle(2);
      wr(A_PEND, 16'h0002); rd(A_PEND);
      wr(A_PEND, 16'h0002); rd(A_PEND);

      // Software set on several sources, SET read, bulk clear.
      wr(A_PEND, 16'h00FF);
      wr(A_SET, 16'hFFA5); wr(A_MASK, 16'h00FF); idle(1); rd(A_SET);
      wr(A_PEND, 16'h00A5); idle(3);

      // Polarity writes on a static high input, unmatched address read.
      cur_irq = 8'hFF; idle(4); wr(A_PEND, 16'h00FF);
      wr(A_POL, 16'h00FF); wr(A_POL, 16'h0000); idle(3); rd(A_PEND);
      rd(16'h0404); rd(16'h03FF);

      // Reset in the middle of an active request.
      wr(A_PEND, 16'h00FF); cur_irq = 8'h00; idle(4); wr(A_PEND, 16'h00FF);
      wr(A_MASK, 16'h0010); wr(A_SET, 16'h0010); idle(2);
      do_reset();
      idle(4); rd(A_PEND); rd(A_MASK);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         int op;
         logic [15:0] addr;
         if ($urandom_range(0, 3) == 0) cur_irq = cur_irq ^ (8'($urandom) & 8'($urandom));
         addr = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'h0400 + 16'($urandom_range(0, 5));
         op = $urandom_range(0, 19);
         if (op == 19 && $urandom_range(0, 20) == 0) do_reset();
         else if (op < 6)  idle(1);
         else if (op < 12) rd(addr);
         else if (op < 18) wr(addr, 16'($urandom));
         else              step(1'b1, 1'b1, addr, 16'($urandom));
      end
      idle(2);

      // Drain the scoreboard within a bounded number of cycles.
      for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
